pc_fetch_gen: RTL and testbench
===============================

// Module: pc_fetch_gen
// PURPOSE
//  Next-generation fetch PC generator; replaces the single-issue PC register at the head of the front end.
//  Emits one aligned fetch-group address per accepted request (FETCH_WIDTH instructions) plus a slot-valid mask.
//  Uses a valid/ready handshake towards the I-cache and redirects on exception flush or branch.
//  A branch that arrives while the front end is stalled is held pending, not dropped.
//  Drives ADEF for misaligned PCs.
// PARAMETERS
//  ADDR_WIDTH   32            PC width in bits
//  FETCH_WIDTH  4             instructions per fetch group; power of two, 1..8 (1 = single-issue behaviour)
//  RESET_PC     32'h1C000000  PC loaded at reset
// PORTS
//  clk                    in   1               system clock, rising edge
//  rst                    in   1               asynchronous, active-low reset
//  pause                  in   6               pipeline stall vector; only pause[0] is used here
//  is_branch_i            in   1               branch redirect request, single-cycle
//  branch_target_addr_i   in   ADDR_WIDTH      branch target
//  exception_flush        in   1               exception redirect, highest priority
//  exception_handle_pc_i  in   ADDR_WIDTH      exception entry PC
//  fetch_ready_i          in   1               I-cache accepts the current request
//  pc_o                   out  ADDR_WIDTH      fetch PC (first valid slot address)
//  inst_en_o              out  1               fetch request valid
//  slot_mask_o            out  FETCH_WIDTH     bit i = slot i of the group is valid
//  is_exception_o         out  1               pc_o misaligned
//  exception_cause_o      out  7               `EXCEPTION_ADEF when misaligned, else 0
// BEHAVIOUR
//  - GB = log2(FETCH_WIDTH)+2; grp(pc) = pc with bits [GB-1:0] cleared.
//  - fire = inst_en_o & fetch_ready_i & ~pause[0].
//  - FSM states:
//    - BOOT: reset state; inst_en_o=0; moves to RUN after one clk.
//    - RUN: inst_en_o=1.
//    - EXC: inst_en_o=0.
//  - Reset values: pc_o=RESET_PC, inst_en_o=0, pend_vld=0, pend_pc=0, state=BOOT.
//  - Registered pc_o update per cycle, highest priority first:
//    1. exception_flush: pc_o<=exception_handle_pc_i; clear pend_vld; state<=RUN. Applies in any state except BOOT.
//    2. pause[0]: pc_o held. If is_branch_i: pend_pc<=target, pend_vld<=1; a newer branch overwrites the pending one.
//    3. is_branch_i: pc_o<=target; clear pend_vld.
//    4. pend_vld: pc_o<=pend_pc; clear pend_vld.
//    5. fire: pc_o<=grp(pc_o)+FETCH_WIDTH*4, modulo 2^ADDR_WIDTH; wrap-around is silent.
//    6. otherwise: hold.
//  - Redirects (rules 1, 3, 4) cancel an unaccepted request: pc_o may change while inst_en_o=1 & ~fetch_ready_i.
//  - slot_mask_o is combinational from pc_o: bit i = (i >= pc_o[GB-1:2]).
//  - is_exception_o = (pc_o[1:0]!=0); combinational.
//  - Entering RUN with a misaligned pc_o moves the FSM to EXC the same cycle: inst_en_o is gated to 0 combinationally.
//  - EXC: pc_o is frozen; is_branch_i and the pending branch are ignored; only exception_flush leaves EXC.
//  - Latency: redirect to new pc_o is 1 cycle; a pending branch is applied on the first cycle with pause[0]=0.
//  - Reset asserted mid-operation: all state returns to its reset value immediately (asynchronous); any pending branch is lost.
// CONFIGURATION
//  - PC_PERF_CNT_EN defined: adds ports perf_fetch_cnt_o[31:0] (+1 per fire) and perf_redirect_cnt_o[31:0] (+1 per applied rule 1/3/4).
//    Both counters reset to 0 and wrap at 2^32.
//  - PC_PERF_CNT_EN undefined: the ports and counters do not exist; all other behaviour is identical.
// TESTING  (FETCH_WIDTH=4, RESET_PC default)
//  1. Release rst, ready=1 -> BOOT cycle inst_en_o=0 pc=1C000000; then pc 1C000000, 1C000010, 1C000020 with mask 4'b1111.
//  2. Branch to 1C000108 -> next pc=1C000108 mask=4'b1100; following fire pc=1C000110 mask=4'b1111.
//  3. pause[0]=1 for 3 cycles, 1-cycle branch to 1C000200 in the first -> pc held 3 cycles; pc=1C000200 on the cycle after pause drops.
//  4. ready=0 for 2 cycles -> pc held; branch to 1C000300 while ready=0 -> pc=1C000300 next cycle, inst_en_o stays 1.
//  5. Branch to 1C000402 -> is_exception_o=1, cause=ADEF, inst_en_o=0; further branches ignored.
//     Then exception_flush with 1C008000 -> pc=1C008000, inst_en_o=1, mask=4'b1111.
//  6. flush(1C008000) + is_branch_i(1C000500) + pause[0] in the same cycle -> pc=1C008000, pend_vld=0.
//     With PC_PERF_CNT_EN: redirect count +1 only.

Source files
------------

// File: rtl/pc_fetch_gen.sv
// pc_fetch_gen: fetch-group PC generator with valid/ready handshake, held branches and ADEF.
// Optional PC_PERF_CNT_EN adds fetch and redirect performance counters.
`ifndef EXCEPTION_ADEF
`define EXCEPTION_ADEF 7'h08
`endif
module pc_fetch_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int FETCH_WIDTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h1C000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             pause,
    input  logic                   is_branch_i,
    input  logic [ADDR_WIDTH-1:0]  branch_target_addr_i,
    input  logic                   exception_flush,
    input  logic [ADDR_WIDTH-1:0]  exception_handle_pc_i,
    input  logic                   fetch_ready_i,
`ifdef PC_PERF_CNT_EN
    output logic [31:0]            perf_fetch_cnt_o,
    output logic [31:0]            perf_redirect_cnt_o,
`endif
    output logic [ADDR_WIDTH-1:0]  pc_o,
    output logic                   inst_en_o,
    output logic [FETCH_WIDTH-1:0] slot_mask_o,
    output logic                   is_exception_o,
    output logic [6:0]             exception_cause_o
);
    localparam int GB = $clog2(FETCH_WIDTH) + 2;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = (ADDR_WIDTH'(1) << GB) - ADDR_WIDTH'(1);

    typedef enum logic [1:0] {BOOT, RUN, EXC} state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt, r_pend_pc, w_pend_pc_nxt, w_off;
    logic                  r_pend_vld, w_pend_vld_nxt;
    logic                  w_mis, w_flush, w_exc, w_en, w_fire, w_redirect;
    logic                  w_pause_unused;

    assign w_pause_unused = ^pause[5:1];
    assign w_mis   = r_pc[1:0] != 2'b00;
    assign w_flush = exception_flush & (r_state != BOOT);
    // A misaligned PC in RUN behaves as EXC already this cycle.
    assign w_exc   = (r_state == EXC) | ((r_state == RUN) & w_mis);
    assign w_en    = (r_state == RUN) & ~w_mis;
    assign w_fire  = w_en & fetch_ready_i & ~pause[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC;
            r_pend_pc  <= '0;
            r_pend_vld <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pend_pc  <= w_pend_pc_nxt;
            r_pend_vld <= w_pend_vld_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_pend_pc_nxt  = r_pend_pc;
        w_pend_vld_nxt = r_pend_vld;
        w_redirect     = 1'b0;
        if (w_flush) begin
            w_pc_nxt       = exception_handle_pc_i;
            w_pend_vld_nxt = 1'b0;
            w_state_nxt    = RUN;
            w_redirect     = 1'b1;
        end else if (w_exc) begin
            w_state_nxt = EXC;
        end else begin
            if (r_state == BOOT)
                w_state_nxt = RUN;
            if (pause[0]) begin
                if (is_branch_i) begin
                    w_pend_pc_nxt  = branch_target_addr_i;
                    w_pend_vld_nxt = 1'b1;
                end
            end else if (is_branch_i) begin
                w_pc_nxt       = branch_target_addr_i;
                w_pend_vld_nxt = 1'b0;
                w_redirect     = 1'b1;
            end else if (r_pend_vld) begin
                w_pc_nxt       = r_pend_pc;
                w_pend_vld_nxt = 1'b0;
                w_redirect     = 1'b1;
            end else if (w_fire) begin
                w_pc_nxt = (r_pc & ~OFF_MASK) + ADDR_WIDTH'(FETCH_WIDTH * 4);
            end
        end
    end

    assign w_off = (r_pc & OFF_MASK) >> 2;

    always_comb begin
        slot_mask_o = '0;
        for (int i = 0; i < FETCH_WIDTH; i++)
            slot_mask_o[i] = ADDR_WIDTH'(i) >= w_off;
    end

    assign pc_o              = r_pc;
    assign inst_en_o         = w_en;
    assign is_exception_o    = w_mis;
    assign exception_cause_o = w_mis ? `EXCEPTION_ADEF : 7'd0;

`ifdef PC_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt_o    <= '0;
            perf_redirect_cnt_o <= '0;
        end else begin
            perf_fetch_cnt_o    <= perf_fetch_cnt_o + 32'(w_fire);
            perf_redirect_cnt_o <= perf_redirect_cnt_o + 32'(w_redirect);
        end
    end
`else
    logic w_redirect_unused;
    assign w_redirect_unused = w_redirect;
`endif
endmodule

// File: tb/tb_pc_fetch_gen.sv
// tb_pc_fetch_gen: table-driven directed check of pc_fetch_gen (FETCH_WIDTH=4).
`ifndef EXCEPTION_ADEF
`define EXCEPTION_ADEF 7'h08
`endif
module tb_pc_fetch_gen;
    typedef struct {
        logic        pause;
        logic        br;
        logic [31:0] tgt;
        logic        flush;
        logic [31:0] fpc;
        logic        ready;
        logic [31:0] pc;
        logic        en;
        logic [3:0]  mask;
        logic        exc;
    } vec_t;

    logic        clk = 0, rst = 0;
    logic [5:0]  pause = '0;
    logic        is_branch_i = 0, exception_flush = 0, fetch_ready_i = 1;
    logic [31:0] branch_target_addr_i = '0, exception_handle_pc_i = '0;
    logic [31:0] pc_o;
    logic        inst_en_o, is_exception_o;
    logic [3:0]  slot_mask_o;
    logic [6:0]  exception_cause_o;
`ifdef PC_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_o, perf_redirect_cnt_o, f0, r0;
`endif
    int n_chk = 0, n_fail = 0;
    vec_t v[27];

    pc_fetch_gen #(.ADDR_WIDTH(32), .FETCH_WIDTH(4), .RESET_PC(32'h1C000000)) dut (
        .clk(clk), .rst(rst), .pause(pause), .is_branch_i(is_branch_i),
        .branch_target_addr_i(branch_target_addr_i), .exception_flush(exception_flush),
        .exception_handle_pc_i(exception_handle_pc_i), .fetch_ready_i(fetch_ready_i),
`ifdef PC_PERF_CNT_EN
        .perf_fetch_cnt_o(perf_fetch_cnt_o), .perf_redirect_cnt_o(perf_redirect_cnt_o),
`endif
        .pc_o(pc_o), .inst_en_o(inst_en_o), .slot_mask_o(slot_mask_o),
        .is_exception_o(is_exception_o), .exception_cause_o(exception_cause_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic p, logic b, logic [31:0] t, logic f, logic [31:0] fp,
                                logic r, logic [31:0] epc, logic een, logic [3:0] em, logic ex);
        vec_t x;
        x.pause = p; x.br = b; x.tgt = t; x.flush = f; x.fpc = fp; x.ready = r;
        x.pc = epc; x.en = een; x.mask = em; x.exc = ex;
        return x;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(string tag, logic [31:0] epc, logic een, logic [3:0] em, logic ex);
        chk({tag, " pc"}, pc_o, epc);
        chk({tag, " inst_en"}, 32'(inst_en_o), 32'(een));
        chk({tag, " mask"}, 32'(slot_mask_o), 32'(em));
        chk({tag, " is_exc"}, 32'(is_exception_o), 32'(ex));
        chk({tag, " cause"}, 32'(exception_cause_o), ex ? 32'(`EXCEPTION_ADEF) : 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        v[0]  = mk(0, 0, 0,            0, 0,            1, 32'h1C000000, 1, 4'hF, 0);
        v[1]  = mk(0, 0, 0,            0, 0,            1, 32'h1C000010, 1, 4'hF, 0);
        v[2]  = mk(0, 0, 0,            0, 0,            1, 32'h1C000020, 1, 4'hF, 0);
        v[3]  = mk(0, 1, 32'h1C000108, 0, 0,            1, 32'h1C000108, 1, 4'hC, 0);
        v[4]  = mk(0, 0, 0,            0, 0,            1, 32'h1C000110, 1, 4'hF, 0);
        v[5]  = mk(1, 1, 32'h1C000200, 0, 0,            1, 32'h1C000110, 1, 4'hF, 0);
        v[6]  = mk(1, 0, 0,            0, 0,            1, 32'h1C000110, 1, 4'hF, 0);
        v[7]  = mk(1, 0, 0,            0, 0,            1, 32'h1C000110, 1, 4'hF, 0);
        v[8]  = mk(0, 0, 0,            0, 0,            1, 32'h1C000200, 1, 4'hF, 0);
        v[9]  = mk(0, 0, 0,            0, 0,            1, 32'h1C000210, 1, 4'hF, 0);
        v[10] = mk(0, 0, 0,            0, 0,            0, 32'h1C000210, 1, 4'hF, 0);
        v[11] = mk(0, 0, 0,            0, 0,            0, 32'h1C000210, 1, 4'hF, 0);
        v[12] = mk(0, 1, 32'h1C000300, 0, 0,            0, 32'h1C000300, 1, 4'hF, 0);
        v[13] = mk(0, 0, 0,            0, 0,            1, 32'h1C000310, 1, 4'hF, 0);
        v[14] = mk(0, 1, 32'h1C000402, 0, 0,            1, 32'h1C000402, 0, 4'hF, 1);
        v[15] = mk(0, 1, 32'h1C000600, 0, 0,            1, 32'h1C000402, 0, 4'hF, 1);
        v[16] = mk(0, 0, 0,            0, 0,            1, 32'h1C000402, 0, 4'hF, 1);
        v[17] = mk(0, 0, 0,            1, 32'h1C008000, 1, 32'h1C008000, 1, 4'hF, 0);
        v[18] = mk(0, 0, 0,            0, 0,            1, 32'h1C008010, 1, 4'hF, 0);
        v[19] = mk(1, 1, 32'h1C000500, 1, 32'h1C008000, 1, 32'h1C008000, 1, 4'hF, 0);
        v[20] = mk(0, 0, 0,            0, 0,            1, 32'h1C008010, 1, 4'hF, 0);
        v[21] = mk(1, 1, 32'h1C000700, 0, 0,            1, 32'h1C008010, 1, 4'hF, 0);
        v[22] = mk(1, 1, 32'h1C000740, 0, 0,            1, 32'h1C008010, 1, 4'hF, 0);
        v[23] = mk(0, 0, 0,            0, 0,            1, 32'h1C000740, 1, 4'hF, 0);
        v[24] = mk(0, 0, 0,            0, 0,            1, 32'h1C000750, 1, 4'hF, 0);
        v[25] = mk(0, 1, 32'hFFFFFFF4, 0, 0,            1, 32'hFFFFFFF4, 1, 4'hE, 0);
        v[26] = mk(0, 0, 0,            0, 0,            1, 32'h00000000, 1, 4'hF, 0);

        tick();
        tick();
        chk_out("reset", 32'h1C000000, 0, 4'hF, 0);
        rst = 1;
        #1;
        chk_out("boot", 32'h1C000000, 0, 4'hF, 0);

        for (int i = 0; i < 27; i++) begin
            pause                 = {5'b0, v[i].pause};
            is_branch_i           = v[i].br;
            branch_target_addr_i  = v[i].tgt;
            exception_flush       = v[i].flush;
            exception_handle_pc_i = v[i].fpc;
            fetch_ready_i         = v[i].ready;
`ifdef PC_PERF_CNT_EN
            f0 = perf_fetch_cnt_o;
            r0 = perf_redirect_cnt_o;
`endif
            tick();
            chk_out($sformatf("vec%0d", i), v[i].pc, v[i].en, v[i].mask, v[i].exc);
`ifdef PC_PERF_CNT_EN
            if (i == 19) begin
                chk("perf fetch delta", perf_fetch_cnt_o - f0, 32'd0);
                chk("perf redirect delta", perf_redirect_cnt_o - r0, 32'd1);
            end
`endif
        end

        pause = 6'b1;
        is_branch_i = 1;
        branch_target_addr_i = 32'h1C000900;
        exception_flush = 0;
        fetch_ready_i = 1;
        tick();
        pause = '0;
        is_branch_i = 0;
        #2;
        rst = 0;
        #1;
        chk_out("async reset", 32'h1C000000, 0, 4'hF, 0);
        tick();
        rst = 1;
        exception_flush = 1;
        exception_handle_pc_i = 32'h1C008000;
        tick();
        chk_out("boot ignores flush", 32'h1C000000, 1, 4'hF, 0);
        exception_flush = 0;
        tick();
        chk_out("pending lost", 32'h1C000010, 1, 4'hF, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
